video_fetch: RTL and testbench

- VGA-side reader for the video words held in ram_vid, driving the read-only B port (addr_B in, DataVideo out).
- On a frame-start request it walks the five video addresses in order and captures each returned word into shadow registers.
- It then commits all five words atomically to output registers, so the renderer never sees a half-updated frame.
- Sits between the memory subsystem and the VGA timing/render logic; it never writes memory.

---
 rtl/video_fetch.sv | 129 ++++++++++++
 tb/tb_video_fetch.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_fetch.sv
// Port-B video word fetcher: reads five fixed addresses into shadow registers, then commits them together.
// Optional build macro VIDEO_FETCH_CHG_EN adds the per-word word_changed output.
module video_fetch #(
    parameter int READ_LAT     = 1,
    parameter int AUTO_RESTART = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic [31:0]  addr_B,
    input  logic [31:0]  DataVideo,
    output logic         busy,
    output logic         frame_done,
`ifdef VIDEO_FETCH_CHG_EN
    output logic [4:0]   word_changed,
`endif
    output logic [159:0] frame_words
);

    typedef enum logic [1:0] {IDLE, REQ, CAP, COMMIT} state_t;

    localparam logic [1:0] LAT_LAST = 2'(READ_LAT - 1);
    localparam logic [2:0] LAST_IDX = 3'd4;

    state_t       state_reg, state_next;
    logic [2:0]   idx_reg, idx_next;
    logic [1:0]   cnt_reg, cnt_next;
    logic [159:0] shadow_reg;
    logic [159:0] frame_words_reg;
    logic         frame_done_reg;

    function automatic logic [31:0] table_addr(input logic [2:0] i);
        case (i)
            3'd1:    return 32'h0000_7000;
            3'd2:    return 32'h0000_8000;
            3'd3:    return 32'h0000_9000;
            3'd4:    return 32'h0001_0000;
            default: return 32'h0000_6000;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            idx_reg   <= 3'd0;
            cnt_reg   <= 2'd0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                idx_next = 3'd0;
                cnt_next = 2'd0;
                if (start) state_next = REQ;
            end
            REQ: begin
                // The address must stay put for the full read latency before data is valid.
                if (cnt_reg == LAT_LAST) state_next = CAP;
                else                     cnt_next   = cnt_reg + 2'd1;
            end
            CAP: begin
                cnt_next = 2'd0;
                if (idx_reg == LAST_IDX) begin
                    state_next = COMMIT;
                end else begin
                    idx_next   = idx_reg + 3'd1;
                    state_next = REQ;
                end
            end
            COMMIT: begin
                idx_next   = 3'd0;
                cnt_next   = 2'd0;
                state_next = (AUTO_RESTART != 0) ? REQ : IDLE;
            end
            default: begin
                state_next = IDLE;
                idx_next   = 3'd0;
                cnt_next   = 2'd0;
            end
        endcase
    end

`ifdef VIDEO_FETCH_CHG_EN
    logic [4:0] word_changed_reg;
    logic [4:0] chg_next;

    for (genvar gi = 0; gi < 5; gi++) begin : g_chg
        assign chg_next[gi] = (shadow_reg[32*gi +: 32] != frame_words_reg[32*gi +: 32]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 word_changed_reg <= 5'd0;
        else if (state_reg == COMMIT) word_changed_reg <= chg_next;
    end

    assign word_changed = word_changed_reg;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_reg      <= '0;
            frame_words_reg <= '0;
            frame_done_reg  <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            if (state_reg == CAP)
                shadow_reg[{idx_reg, 5'd0} +: 32] <= DataVideo;
            // Whole-frame commit keeps the renderer from ever seeing a mix of old and new words.
            if (state_reg == COMMIT) begin
                frame_words_reg <= shadow_reg;
                frame_done_reg  <= 1'b1;
            end
        end
    end

    assign busy        = (state_reg != IDLE);
    assign addr_B      = table_addr((state_reg == IDLE) ? 3'd0 : idx_reg);
    assign frame_done  = frame_done_reg;
    assign frame_words = frame_words_reg;

endmodule

// File: tb/tb_video_fetch.sv
// Bench for video_fetch: three instances (READ_LAT=1, READ_LAT=3, AUTO_RESTART=1) against a latency memory model.
module tb_video_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         start_i [3];
    logic [31:0]  addr_o  [3];
    logic [31:0]  data_i  [3];
    logic         busy_o  [3];
    logic         done_o  [3];
    logic [159:0] words_o [3];
`ifdef VIDEO_FETCH_CHG_EN
    logic [4:0]   chg_o   [3];
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0]  tbl [5] = '{32'h0000_6000, 32'h0000_7000, 32'h0000_8000, 32'h0000_9000, 32'h0001_0000};
    logic [31:0]  mem_word [3][5];
    logic [159:0] model_frame [3];
    logic [31:0]  pipe1 [3];
    logic [31:0]  pipe2 [3];
    logic [31:0]  pipe3 [3];

    video_fetch #(.READ_LAT(1), .AUTO_RESTART(0)) dut0 (
        .clk(clk), .reset(rst_n), .start(start_i[0]), .addr_B(addr_o[0]), .DataVideo(data_i[0]),
        .busy(busy_o[0]), .frame_done(done_o[0]),
`ifdef VIDEO_FETCH_CHG_EN
        .word_changed(chg_o[0]),
`endif
        .frame_words(words_o[0]));

    video_fetch #(.READ_LAT(3), .AUTO_RESTART(0)) dut1 (
        .clk(clk), .reset(rst_n), .start(start_i[1]), .addr_B(addr_o[1]), .DataVideo(data_i[1]),
        .busy(busy_o[1]), .frame_done(done_o[1]),
`ifdef VIDEO_FETCH_CHG_EN
        .word_changed(chg_o[1]),
`endif
        .frame_words(words_o[1]));

    video_fetch #(.READ_LAT(1), .AUTO_RESTART(1)) dut2 (
        .clk(clk), .reset(rst_n), .start(start_i[2]), .addr_B(addr_o[2]), .DataVideo(data_i[2]),
        .busy(busy_o[2]), .frame_done(done_o[2]),
`ifdef VIDEO_FETCH_CHG_EN
        .word_changed(chg_o[2]),
`endif
        .frame_words(words_o[2]));

    function automatic logic [31:0] lookup(input int k, input logic [31:0] a);
        for (int i = 0; i < 5; i++)
            if (a == tbl[i]) return mem_word[k][i];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [159:0] frame_of(input int k);
        logic [159:0] f;
        for (int i = 0; i < 5; i++) f[32*i +: 32] = mem_word[k][i];
        return f;
    endfunction

    // Memory: address sampled on the edge, data valid 1 (or 3) cycles later.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            pipe1[k] <= lookup(k, addr_o[k]);
            pipe2[k] <= pipe1[k];
            pipe3[k] <= pipe2[k];
        end
    end
    assign data_i[0] = pipe1[0];
    assign data_i[1] = pipe3[1];
    assign data_i[2] = pipe1[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_mem(input int k);
        for (int i = 0; i < 5; i++) mem_word[k][i] = $urandom;
    endtask

    task automatic run_fetch(input int k, input int lat, input bit poke);
        logic [159:0] exp_words;
        int blen;
        exp_words = frame_of(k);
        blen = 5 * (lat + 1) + 1;
        checks++;
        if (busy_o[k] !== 1'b0 || addr_o[k] !== tbl[0]) begin
            errors++;
            $display("FAIL pre_idle k=%0d busy=%b addr=%h need busy=0 addr=%h", k, busy_o[k], addr_o[k], tbl[0]);
        end
        start_i[k] = 1'b1;
        tick();
        start_i[k] = 1'b0;
        for (int c = 1; c <= blen; c++) begin
            checks++;
            if (busy_o[k] !== 1'b1 || done_o[k] !== 1'b0) begin
                errors++;
                $display("FAIL busy_phase k=%0d T+%0d busy=%b done=%b need busy=1 done=0", k, c, busy_o[k], done_o[k]);
            end
            checks++;
            if (words_o[k] !== model_frame[k]) begin
                errors++;
                $display("FAIL words_stable k=%0d T+%0d got=%h need=%h", k, c, words_o[k], model_frame[k]);
            end
            if (c < blen) begin
                checks++;
                if (addr_o[k] !== tbl[(c - 1) / (lat + 1)]) begin
                    errors++;
                    $display("FAIL addr_seq k=%0d T+%0d got=%h need=%h", k, c, addr_o[k], tbl[(c - 1) / (lat + 1)]);
                end
            end
            start_i[k] = poke && (c == 5);
            tick();
        end
        start_i[k] = 1'b0;
        checks++;
        if (done_o[k] !== 1'b1 || busy_o[k] !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse k=%0d T+%0d done=%b busy=%b need done=1 busy=0", k, blen + 1, done_o[k], busy_o[k]);
        end
        checks++;
        if (words_o[k] !== exp_words) begin
            errors++;
            $display("FAIL frame_words k=%0d got=%h need=%h", k, words_o[k], exp_words);
        end
`ifdef VIDEO_FETCH_CHG_EN
        begin
            logic [4:0] exp_chg;
            for (int i = 0; i < 5; i++)
                exp_chg[i] = (exp_words[32*i +: 32] != model_frame[k][32*i +: 32]);
            checks++;
            if (chg_o[k] !== exp_chg) begin
                errors++;
                $display("FAIL word_changed k=%0d got=%b need=%b", k, chg_o[k], exp_chg);
            end
        end
`endif
        model_frame[k] = exp_words;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (done_o[k] !== 1'b0 || busy_o[k] !== 1'b0 || words_o[k] !== model_frame[k]) begin
                errors++;
                $display("FAIL post_idle k=%0d cyc=%0d done=%b busy=%b words=%h need 0/0/%h",
                         k, c, done_o[k], busy_o[k], words_o[k], model_frame[k]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (busy_o[k] !== 1'b0 || done_o[k] !== 1'b0 || words_o[k] !== '0 || addr_o[k] !== 32'h0000_6000) begin
                    errors++;
                    $display("FAIL reset_vals k=%0d busy=%b done=%b words=%h addr=%h", k, busy_o[k], done_o[k], words_o[k], addr_o[k]);
                end
            end
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) model_frame[k] = '0;
        for (int c = 0; c < 20; c++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (busy_o[k] !== 1'b0 || done_o[k] !== 1'b0 || words_o[k] !== '0 || addr_o[k] !== 32'h0000_6000) begin
                    errors++;
                    $display("FAIL idle_vals k=%0d cyc=%0d busy=%b done=%b words=%h addr=%h", k, c, busy_o[k], done_o[k], words_o[k], addr_o[k]);
                end
`ifdef VIDEO_FETCH_CHG_EN
                checks++;
                if (chg_o[k] !== 5'd0) begin
                    errors++;
                    $display("FAIL idle_chg k=%0d got=%b need=00000", k, chg_o[k]);
                end
`endif
            end
        end
    endtask

    task automatic test_single_fetch();
        for (int i = 0; i < 5; i++) mem_word[0][i] = 32'hA000_0000 + 32'(i);
        run_fetch(0, 1, 1'b0);
        for (int n = 0; n < 2; n++) begin
            randomize_mem(0);
            run_fetch(0, 1, 1'b0);
        end
    endtask

    task automatic test_start_during_busy();
        randomize_mem(0);
        run_fetch(0, 1, 1'b1);
        randomize_mem(0);
        run_fetch(0, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [159:0] first;
        randomize_mem(0);
        first = frame_of(0);
        start_i[0] = 1'b1;
        tick();
        for (int c = 1; c <= 24; c++) begin
            checks++;
            if (busy_o[0] !== ((c != 12) && (c != 24)) || done_o[0] !== ((c == 12) || (c == 24))) begin
                errors++;
                $display("FAIL back_to_back T+%0d busy=%b done=%b", c, busy_o[0], done_o[0]);
            end
            if (c == 12) begin
                checks++;
                if (words_o[0] !== first) begin
                    errors++;
                    $display("FAIL b2b_first got=%h need=%h", words_o[0], first);
                end
                model_frame[0] = first;
                randomize_mem(0);
            end
            if (c == 24) begin
                checks++;
                if (words_o[0] !== frame_of(0)) begin
                    errors++;
                    $display("FAIL b2b_second got=%h need=%h", words_o[0], frame_of(0));
                end
                model_frame[0] = frame_of(0);
                start_i[0] = 1'b0;
            end
            tick();
        end
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (busy_o[0] !== 1'b0 || done_o[0] !== 1'b0) begin
                errors++;
                $display("FAIL b2b_stop cyc=%0d busy=%b done=%b need 0/0", c, busy_o[0], done_o[0]);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_fetch();
        randomize_mem(0);
        start_i[0] = 1'b1;
        tick();
        start_i[0] = 1'b0;
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy_o[0] !== 1'b0 || done_o[0] !== 1'b0 || words_o[0] !== '0 || addr_o[0] !== 32'h0000_6000) begin
            errors++;
            $display("FAIL async_reset busy=%b done=%b words=%h addr=%h need 0/0/0/00006000", busy_o[0], done_o[0], words_o[0], addr_o[0]);
        end
`ifdef VIDEO_FETCH_CHG_EN
        checks++;
        if (chg_o[0] !== 5'd0) begin
            errors++;
            $display("FAIL async_reset_chg got=%b need=00000", chg_o[0]);
        end
`endif
        for (int k = 0; k < 3; k++) model_frame[k] = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        randomize_mem(0);
        run_fetch(0, 1, 1'b0);
    endtask

    task automatic test_read_lat3();
        for (int n = 0; n < 2; n++) begin
            randomize_mem(1);
            run_fetch(1, 3, 1'b0);
        end
    endtask

`ifdef VIDEO_FETCH_CHG_EN
    task automatic test_word_changed();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) model_frame[k] = '0;
        tick();
        mem_word[0][0] = 32'h1234_5678;
        mem_word[0][1] = 32'h9ABC_DEF0;
        mem_word[0][2] = 32'h0000_0011;
        mem_word[0][3] = 32'h0F0F_0F0F;
        mem_word[0][4] = 32'h5555_AAAA;
        run_fetch(0, 1, 1'b0);
        checks++;
        if (chg_o[0] !== 5'b11111) begin
            errors++;
            $display("FAIL chg_first got=%b need=11111", chg_o[0]);
        end
        mem_word[0][2] = 32'h0000_0022;
        run_fetch(0, 1, 1'b0);
        checks++;
        if (chg_o[0] !== 5'b00100) begin
            errors++;
            $display("FAIL chg_second got=%b need=00100", chg_o[0]);
        end
    endtask
`endif

    task automatic test_auto_restart();
        logic [159:0] exp_words;
        randomize_mem(2);
        exp_words = frame_of(2);
        start_i[2] = 1'b1;
        tick();
        start_i[2] = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            checks++;
            if (busy_o[2] !== 1'b1 || done_o[2] !== ((c == 12) || (c == 23))) begin
                errors++;
                $display("FAIL auto_restart T+%0d busy=%b done=%b", c, busy_o[2], done_o[2]);
            end
            if (c == 12 || c == 23) begin
                checks++;
                if (words_o[2] !== exp_words) begin
                    errors++;
                    $display("FAIL auto_words T+%0d got=%h need=%h", c, words_o[2], exp_words);
                end
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start_i[k] = 1'b0;
            model_frame[k] = '0;
            for (int i = 0; i < 5; i++) mem_word[k][i] = 32'h0;
        end
        test_reset();
        test_single_fetch();
        test_start_during_busy();
        test_back_to_back();
        test_reset_mid_fetch();
        test_read_lat3();
`ifdef VIDEO_FETCH_CHG_EN
        test_word_changed();
`endif
        test_auto_restart();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
